// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator running entirely on clk_in with a divided pixel clock-enable.
// A start-up/shutdown FSM gates the raster counters; all sync/coordinate outputs are registered.
module vga_timing_ctrl #(
    parameter int DIV         = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_CYCLES = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    output logic       pix_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       locked
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WW      = $clog2(LOCK_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(LOCK_CYCLES - 1);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEGIN  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEGIN  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [DW-1:0] div_cnt;
    logic [WW-1:0] warm_cnt, warm_next;
    logic [9:0]    h_cnt, v_cnt, h_next, v_next;
    logic          fs_next;
    logic          active_next, de_next, hs_next, vs_next;

    assign pix_ce = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            div_cnt <= '0;
        else if (pix_ce)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            warm_cnt <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            state    <= state_next;
            warm_cnt <= warm_next;
            h_cnt    <= h_next;
            v_cnt    <= v_next;
        end
    end

    // End-of-frame in DRAIN without enable stops instead of wrapping, so no frame_start there.
    always_comb begin
        state_next = state;
        warm_next  = warm_cnt;
        h_next     = h_cnt;
        v_next     = v_cnt;
        fs_next    = 1'b0;
        case (state)
            IDLE: begin
                warm_next = '0;
                h_next    = '0;
                v_next    = '0;
                if (enable)
                    state_next = WARMUP;
            end
            WARMUP: begin
                if (!enable) begin
                    state_next = IDLE;
                    warm_next  = '0;
                end else if (pix_ce) begin
                    if (warm_cnt == WARM_LAST) begin
                        state_next = RUN;
                        warm_next  = '0;
                        h_next     = '0;
                        v_next     = '0;
                        fs_next    = 1'b1;
                    end else begin
                        warm_next = warm_cnt + WW'(1);
                    end
                end
            end
            RUN, DRAIN: begin
                state_next = enable ? RUN : DRAIN;
                if (pix_ce) begin
                    if (h_cnt == H_LAST) begin
                        h_next = '0;
                        if (v_cnt == V_LAST) begin
                            v_next = '0;
                            if (state == DRAIN && !enable)
                                state_next = IDLE;
                            else
                                fs_next = 1'b1;
                        end else begin
                            v_next = v_cnt + 10'd1;
                        end
                    end else begin
                        h_next = h_cnt + 10'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign active_next = (state_next == RUN) || (state_next == DRAIN);
    assign de_next     = (h_next < H_ACT) && (v_next < V_ACT);
    assign hs_next     = (h_next >= HS_BEGIN) && (h_next < HS_END);
    assign vs_next     = (v_next >= VS_BEGIN) && (v_next < VS_END);

    // Decoding the next-state counters keeps the registered outputs aligned with h_cnt/v_cnt.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else if (active_next) begin
            hsync       <= ~hs_next;
            vsync       <= ~vs_next;
            de          <= de_next;
            x           <= de_next ? h_next : 10'd0;
            y           <= de_next ? v_next : 10'd0;
            frame_start <= fs_next;
            locked      <= 1'b1;
        end else begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl using a shrunken raster (15x8 pixels) so whole frames fit in a short run.
// A linear-position reference model predicts every output each clk_in cycle.
module tb_vga_timing_ctrl;

    localparam int DIV   = 4;
    localparam int HA    = 8;
    localparam int HFP   = 2;
    localparam int HS    = 3;
    localparam int HBP   = 2;
    localparam int VA    = 4;
    localparam int VFP   = 1;
    localparam int VS    = 2;
    localparam int VBP   = 1;
    localparam int LOCK  = 16;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int LIMIT = 4 * FRAME * DIV;
    localparam logic [31:0] IDLE_VEC = {6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

    logic       clk_in;
    logic       reset;
    logic       enable;
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       locked;

    logic [25:0] dut_vec;
    assign dut_vec = {pix_ce, hsync, vsync, de, x, y, frame_start, locked};

    int check_count = 0;
    int error_count = 0;
    int cyc_num     = 0;

    logic [31:0] sb_queue[$];

    // Reference model state: mode 0=IDLE 1=WARMUP 2=RUN 3=DRAIN, raster as a linear position.
    int   m_mode = 0;
    int   m_div  = 0;
    int   m_warm = 0;
    int   m_pos  = 0;
    logic m_fs   = 1'b0;

    int   last_fs  = -1;
    int   last_hs  = -1;
    int   de_rise  = -1;
    logic prev_hs  = 1'b1;
    logic prev_de  = 1'b0;

    vga_timing_ctrl #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .enable(enable),
        .pix_ce(pix_ce),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .x(x),
        .y(y),
        .frame_start(frame_start),
        .locked(locked)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc_num);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en);
        @(negedge clk_in);
        reset  = rst;
        enable = en;
    endtask

    function automatic logic [31:0] expectedVec();
        int   h, v;
        logic act, de_e, hs_e, vs_e, pce_e;
        h     = m_pos % HT;
        v     = m_pos / HT;
        act   = (m_mode >= 2);
        de_e  = act && (h < HA) && (v < VA);
        hs_e  = !(act && (h >= HA + HFP) && (h < HA + HFP + HS));
        vs_e  = !(act && (v >= VA + VFP) && (v < VA + VFP + VS));
        pce_e = (m_div == DIV - 1);
        return {6'd0, pce_e, hs_e, vs_e, de_e,
                de_e ? 10'(h) : 10'd0, de_e ? 10'(v) : 10'd0, act && m_fs, act};
    endfunction

    // Advance the model on each clk_in edge and queue the outputs it predicts.
    always @(posedge clk_in) begin
        logic ce;
        int   nxt;
        if (reset) begin
            m_mode = 0; m_div = 0; m_warm = 0; m_pos = 0; m_fs = 1'b0;
        end else begin
            ce    = (m_div == DIV - 1);
            m_div = ce ? 0 : m_div + 1;
            m_fs  = 1'b0;
            case (m_mode)
                0: if (enable) begin m_mode = 1; m_warm = 0; end
                1: begin
                    if (!enable) m_mode = 0;
                    else if (ce) begin
                        m_warm++;
                        if (m_warm == LOCK) begin m_mode = 2; m_pos = 0; m_fs = 1'b1; end
                    end
                end
                default: begin
                    nxt = enable ? 2 : 3;
                    if (ce) begin
                        if (m_pos == FRAME - 1) begin
                            if (m_mode == 3 && !enable) begin nxt = 0; m_pos = 0; end
                            else begin m_pos = 0; m_fs = 1'b1; end
                        end else begin
                            m_pos++;
                        end
                    end
                    m_mode = nxt;
                end
            endcase
        end
        sb_queue.push_back(expectedVec());
    end

    // Compare just after the edge and track period/width of frame_start, hsync and de.
    always @(posedge clk_in) begin
        #1;
        cyc_num++;
        if (sb_queue.size() > 0)
            checkOutput("cycle", {6'd0, dut_vec}, sb_queue.pop_front());
        if (reset || !locked) begin
            last_fs = -1; last_hs = -1; de_rise = -1;
        end else begin
            if (frame_start) begin
                if (last_fs >= 0) checkOutput("frame_period", cyc_num - last_fs, FRAME * DIV);
                last_fs = cyc_num;
            end
            if (hsync && !prev_hs) begin
                if (last_hs >= 0) checkOutput("line_period", cyc_num - last_hs, HT * DIV);
                last_hs = cyc_num;
            end
            if (de && !prev_de) de_rise = cyc_num;
            if (!de && prev_de && de_rise >= 0) checkOutput("de_width", cyc_num - de_rise, HA * DIV);
        end
        prev_hs = hsync;
        prev_de = de;
    end

    initial begin
        int n, pce_cnt, fs_seen, t0;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("reset_values", {6'd0, dut_vec}, IDLE_VEC);
        applyStimulus(1'b0, 1'b0);
        repeat (24) @(negedge clk_in);

        $display("[TB] start-up from IDLE");
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (!frame_start && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        checkOutput("lock_reached", 32'(frame_start), 32'd1);
        checkOutput("first_pixel", {28'd0, de, locked, x == 10'd0, y == 10'd0}, 32'hF);
        t0 = cyc_num;
        n = 0;
        while (!(de && x == 10'(HA - 1)) && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        checkOutput("x_last_delay", cyc_num - t0, (HA - 1) * DIV);
        repeat (2 * FRAME * DIV) @(negedge clk_in);

        $display("[TB] drain to IDLE");
        n = 0;
        while (!(de && y == 10'd2) && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        applyStimulus(1'b0, 1'b0);
        fs_seen = 0;
        n = 0;
        while (locked && n < LIMIT) begin @(posedge clk_in); #2; n++; fs_seen += int'(frame_start); end
        checkOutput("drain_unlock", 32'(locked), 32'd0);
        checkOutput("drain_no_fs", fs_seen, 0);
        checkOutput("drain_de", 32'(de), 32'd0);
        repeat (10) @(negedge clk_in);

        $display("[TB] enable toggle during frame");
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (!frame_start && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        checkOutput("relock", 32'(frame_start), 32'd1);
        t0 = cyc_num;
        n = 0;
        while (!(de && y == 10'd1) && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (!(de && y == 10'd3) && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        checkOutput("raster_continues", 32'(locked), 32'd1);
        applyStimulus(1'b0, 1'b1);
        n = 0;
        do begin @(posedge clk_in); #2; n++; end while (!frame_start && n < LIMIT);
        checkOutput("toggle_frame_period", cyc_num - t0, FRAME * DIV);

        $display("[TB] reset mid-line");
        n = 0;
        while (!(de && y == 10'd1 && x == 10'd5) && n < LIMIT) begin @(posedge clk_in); #2; n++; end
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_async", {6'd0, dut_vec}, IDLE_VEC);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        pce_cnt = 0;
        n = 0;
        while (n < LIMIT) begin
            @(posedge clk_in); #2; n++;
            if (frame_start) break;
            pce_cnt += int'(pix_ce);
        end
        checkOutput("rewarm_pulses", pce_cnt, LOCK);
        checkOutput("rewarm_cycles", n, LOCK * DIV);
        repeat (FRAME * DIV + 20) @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequences the VGA pixel datapath from the 100 MHz system clock. A free-running divider generates the pixel clock-enable, so no derived clock is needed. A start-up/shutdown state machine gates the horizontal/vertical raster counters. The block drives registered hsync, vsync, data-enable, pixel coordinates and frame-start to the pixel generator and the VGA pins. It replaces derived-clock pixel timing: everything runs on clk_in.

## Interface
- DIV, 4: clk_in cycles per pixel (100 MHz / 4 = 25 MHz pixel rate).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- LOCK_CYCLES, 16: pix_ce pulses spent in WARMUP before the raster starts.
- clk_in  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high.
- enable  input  1  level request to run the raster.
- pix_ce  output  1  one-clk_in-cycle pixel enable pulse.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- de  output  1  active-video data enable.
- x  output  10  pixel column while de=1, else 0.
- y  output  10  pixel row while de=1, else 0.
- frame_start  output  1  one-cycle pulse when the raster enters (0,0).
- locked  output  1  high in RUN and DRAIN.

## Operation
- The divider counter runs from 0 to DIV-1. pix_ce=1 on the cycle the counter equals DIV-1.
- The divider runs in every state and wraps to 0.
- H_TOTAL is H_ACTIVE+H_FP+H_SYNC+H_BP, which is 800 with the defaults. V_TOTAL is the same sum of the V_ parameters, 525 with the defaults. Both totals must be 1024 or less, because h_cnt and v_cnt are 10 bits.
- States and transitions:
  - IDLE → WARMUP when enable=1.
  - WARMUP counts pix_ce pulses. On the LOCK_CYCLES-th pulse it enters RUN with h=v=0 and pulses frame_start.
  - In WARMUP, enable=0 returns to IDLE and clears the warm-up count.
  - RUN → DRAIN when enable=0, on the next clk_in edge.
  - DRAIN → RUN when enable=1; the counters are not disturbed.
  - In DRAIN, the pix_ce at h=H_TOTAL-1 and v=V_TOTAL-1 goes to IDLE instead of wrapping. There is no frame_start on that edge.
  - Re-entry from IDLE always passes through WARMUP again.
- Raster counters advance only on pix_ce while in RUN or DRAIN:
  - h increments and wraps at H_TOTAL-1 to 0.
  - When h wraps, v increments, and v wraps at V_TOTAL-1 to 0.
- Output decode applies in RUN and DRAIN. Outputs are registered from the next-state counter values, so they match the current counters with zero pixel lag.
  - de=1 when h<H_ACTIVE and v<V_ACTIVE.
  - hsync=0 when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, which is 656..751 with the defaults.
  - vsync=0 when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, which is 490..491 with the defaults.
  - x=h and y=v while de=1; otherwise x=0 and y=0.
  - frame_start=1 for one clk_in cycle on the edge at which the counters become (0,0), including the first entry into RUN.
- In IDLE and WARMUP the outputs hold idle values: hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0, locked=0.

## Timing
- Reset values (asynchronous, applied immediately):
  - State IDLE; divider, h_cnt, v_cnt and warm-up count all 0.
  - pix_ce=0, hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0, locked=0.
- Reset asserted mid-operation aborts everything instantly. There is no drain.
- First pix_ce comes on the DIV-th clk_in edge after reset deasserts.
- Steady-state periods with the defaults:
  - One pixel = 4 clk_in cycles.
  - One line = 3200 clk_in cycles.
  - One frame = 1,680,000 clk_in cycles.
- de, hsync, vsync, x, y and frame_start change only on clk_in edges where pix_ce=1. The exception is reset.
- locked:
  - Rises on the edge entering RUN, which is the same edge as the first frame_start.
  - Falls on the edge entering IDLE from DRAIN or WARMUP.
- If enable toggles 1→0→1 within RUN or DRAIN before the frame ends, the raster is uninterrupted and no extra frame_start is generated.
- If enable and a pix_ce arrive in the same cycle in IDLE, the transition to WARMUP happens but that pulse is not counted. Counting starts with the next pulse.

## Test plan
- Reset release with enable=0:
  - pix_ce pulses on edges 4, 8, 12, … after release.
  - hsync=vsync=1, de=0, locked=0 throughout.
- Raise enable from IDLE:
  - locked and frame_start rise on the 16th pix_ce pulse after WARMUP entry.
  - de=1 with x=0, y=0 on that same edge.
  - x=639 at 639 pixels later; de=0 at h=640.
- Line timing:
  - de high for 640 pixels (2560 clk_in cycles).
  - hsync low for 96 pixels starting at h=656.
  - Rising edges of hsync spaced 3200 clk_in cycles apart.
- Frame timing:
  - vsync low exactly for lines 490–491.
  - de low for lines 480–524.
  - frame_start pulses every 1,680,000 clk_in cycles.
- Drain:
  - Drop enable at y=100: the frame completes through h=799, v=524, then locked=0 and de=0, with no frame_start.
  - Separately, drop enable at y=100 and re-raise it at y=300: the raster is continuous and the next frame_start comes on time.
- Reset mid-line:
  - Assert reset at h=300, v=50: all outputs take reset values in the same cycle.
  - After release, restarting with enable=1 requires 16 pix_ce pulses of warm-up before frame_start.
